// File: rtl/pong_frame_scheduler.sv
// ---------------------------------------------------------------------------
// pong_frame_scheduler: per-frame sequencer that stalls the CPU, loads game
// inputs into the regfile and latches ball x/y for the VGA side.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pong_frame_scheduler #(
  parameter int NUM_IN      = 4,
  parameter int IN_BASE_REG = 20,
  parameter int BALLX_REG   = 28,
  parameter int BALLY_REG   = 29
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 screen_end,
  input  logic [NUM_IN*32-1:0] in_data,
  input  logic                 cpu_we,
  input  logic [4:0]           cpu_wreg,
  input  logic [31:0]          cpu_wdata,
  output logic                 rf_we,
  output logic [4:0]           rf_wreg,
  output logic [31:0]          rf_wdata,
  output logic [4:0]           rf_rreg,
  input  logic [31:0]          rf_rdata,
  output logic                 cpu_stall,
  output logic [31:0]          ball_x,
  output logic [31:0]          ball_y,
  output logic [15:0]          frame_count,
  output logic                 overrun,
  output logic                 conflict
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STALL = 3'd1,
    LOAD  = 3'd2,
    RDX   = 3'd3,
    RDY   = 3'd4
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             prev_se;
  logic             pending;
  logic [31:0]      snap [NUM_IN];
  logic             se_edge;

  assign se_edge = screen_end & ~prev_se;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idx         <= '0;
      prev_se     <= 1'b0;
      pending     <= 1'b0;
      ball_x      <= '0;
      ball_y      <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
      conflict    <= 1'b0;
      for (int k = 0; k < NUM_IN; k++) snap[k] <= '0;
    end else begin
      prev_se <= screen_end;
      if (cpu_we && cpu_stall) conflict <= 1'b1;

      // Only one frame request can be queued; any further edge is lost.
      if (state != IDLE && se_edge) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (se_edge || pending) begin
            for (int k = 0; k < NUM_IN; k++) snap[k] <= in_data[k*32 +: 32];
            pending <= 1'b0;
            state   <= STALL;
          end
        end
        STALL: begin
          idx   <= '0;
          state <= LOAD;
        end
        LOAD: begin
          if (idx == IDX_W'(NUM_IN - 1)) state <= RDX;
          else                           idx   <= idx + 1'b1;
        end
        RDX: begin
          ball_x <= rf_rdata;
          state  <= RDY;
        end
        RDY: begin
          ball_y      <= rf_rdata;
          frame_count <= frame_count + 16'd1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_stall = (state != IDLE);
    rf_we     = 1'b0;
    rf_wreg   = '0;
    rf_wdata  = '0;
    rf_rreg   = '0;
    case (state)
      IDLE: begin
        // Gated by reset so every output reads zero while reset is held.
        rf_we    = cpu_we & reset;
        rf_wreg  = reset ? cpu_wreg  : '0;
        rf_wdata = reset ? cpu_wdata : '0;
      end
      LOAD: begin
        rf_we    = 1'b1;
        rf_wreg  = 5'(IN_BASE_REG) + 5'(idx);
        rf_wdata = snap[idx];
      end
      RDX:     rf_rreg = 5'(BALLX_REG);
      RDY:     rf_rreg = 5'(BALLY_REG);
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pong_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_pong_frame_scheduler: directed bench with a regfile model and a queue of
// expected regfile writes.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pong_frame_scheduler;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         screen_end = 1'b0;
  logic [127:0] in_data = '0;
  logic         cpu_we = 1'b0;
  logic [4:0]   cpu_wreg = '0;
  logic [31:0]  cpu_wdata = '0;
  logic         rf_we;
  logic [4:0]   rf_wreg;
  logic [31:0]  rf_wdata;
  logic [4:0]   rf_rreg;
  logic [31:0]  rf_rdata;
  logic         cpu_stall;
  logic [31:0]  ball_x;
  logic [31:0]  ball_y;
  logic [15:0]  frame_count;
  logic         overrun;
  logic         conflict;

  pong_frame_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .screen_end  (screen_end),
    .in_data     (in_data),
    .cpu_we      (cpu_we),
    .cpu_wreg    (cpu_wreg),
    .cpu_wdata   (cpu_wdata),
    .rf_we       (rf_we),
    .rf_wreg     (rf_wreg),
    .rf_wdata    (rf_wdata),
    .rf_rreg     (rf_rreg),
    .rf_rdata    (rf_rdata),
    .cpu_stall   (cpu_stall),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .frame_count (frame_count),
    .overrun     (overrun),
    .conflict    (conflict)
  );

  always #5 clock = ~clock;

  // Regfile model: write on rising edge, combinational read port.
  logic [31:0] regs [32] = '{default: '0};
  always @(posedge clock) if (rf_we) regs[rf_wreg] <= rf_wdata;
  assign rf_rdata = regs[rf_rreg];

  typedef struct packed {
    logic [4:0]  wreg;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    wr_t e;
    if (reset === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rf_write", {59'd0, rf_wreg}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("rf_write", {27'd0, rf_wreg, rf_wdata}, {27'd0, e.wreg, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] r, input logic [31:0] d);
    exp_q.push_back('{wreg: r, data: d});
  endtask

  task automatic load_words(input logic [31:0] base);
    in_data = {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endtask

  task automatic expect_load(input logic [31:0] base);
    for (int k = 0; k < 4; k++) push_wr(5'(20 + k), base + 32'(k));
  endtask

  // Counts consecutive falling edges where cpu_stall equals lvl (bounded).
  task automatic count_run(input logic lvl, input string tag, output int n);
    bit done;
    n    = 0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clock);
      if (cpu_stall !== lvl) done = 1'b1;
      else                   n++;
    end
    if (!done) check({tag, "_timeout"}, {63'd0, cpu_stall}, {63'd0, ~lvl});
  endtask

  task automatic cpu_write(input logic [4:0] r, input logic [31:0] d);
    cpu_we = 1'b1; cpu_wreg = r; cpu_wdata = d;
    push_wr(r, d);
    tick();
    cpu_we = 1'b0;
  endtask

  int n, n2;

  initial begin
    // Reset state
    tick(); tick();
    check("rst_stall",   {63'd0, cpu_stall}, 64'd0);
    check("rst_rf_we",   {63'd0, rf_we}, 64'd0);
    check("rst_rreg",    {59'd0, rf_rreg}, 64'd0);
    check("rst_ball_x",  {32'd0, ball_x}, 64'd0);
    check("rst_ball_y",  {32'd0, ball_y}, 64'd0);
    check("rst_frames",  {48'd0, frame_count}, 64'd0);
    check("rst_overrun", {63'd0, overrun}, 64'd0);
    check("rst_conflict",{63'd0, conflict}, 64'd0);
    reset = 1'b1;
    tick();

    // Basic 4-word frame
    load_words(32'd5); expect_load(32'd5);
    screen_end = 1'b1;
    tick();
    count_run(1'b1, "f1", n);
    check("f1_stall_len", n, 64'd7);
    tick();
    check("f1_frames", {48'd0, frame_count}, 64'd1);
    check("f1_q_empty", exp_q.size(), 64'd0);
    screen_end = 1'b0;
    tick();

    // Ball latch and hold
    cpu_write(5'd28, 32'h140);
    cpu_write(5'd29, 32'hF0);
    load_words(32'h100); expect_load(32'h100);
    screen_end = 1'b1;
    tick();
    count_run(1'b1, "f2", n);
    check("f2_stall_len", n, 64'd7);
    tick();
    screen_end = 1'b0;
    check("f2_ball_x", {32'd0, ball_x}, 64'h140);
    check("f2_ball_y", {32'd0, ball_y}, 64'hF0);
    check("f2_frames", {48'd0, frame_count}, 64'd2);
    cpu_write(5'd28, 32'h150);
    tick();
    check("hold_ball_x", {32'd0, ball_x}, 64'h140);
    check("hold_ball_y", {32'd0, ball_y}, 64'hF0);

    // CPU write in edge cycle lands; CPU write during LOAD is blocked
    load_words(32'h200);
    cpu_we = 1'b1; cpu_wreg = 5'd5; cpu_wdata = 32'h1234;
    push_wr(5'd5, 32'h1234);
    expect_load(32'h200);
    screen_end = 1'b1;
    tick();
    cpu_we = 1'b0;
    tick();
    cpu_we = 1'b1; cpu_wreg = 5'd7; cpu_wdata = 32'hDEAD;
    tick();
    cpu_we = 1'b0;
    count_run(1'b1, "f3", n);
    check("f3_stall_rest", n, 64'd5);
    tick();
    screen_end = 1'b0;
    check("f3_conflict", {63'd0, conflict}, 64'd1);
    check("f3_r5", {32'd0, regs[5]}, 64'h1234);
    check("f3_r7_untouched", {32'd0, regs[7]}, 64'd0);
    check("f3_ball_x", {32'd0, ball_x}, 64'h150);
    check("f3_frames", {48'd0, frame_count}, 64'd3);
    check("f3_overrun", {63'd0, overrun}, 64'd0);
    tick();

    // Pending edge during LOAD: back-to-back frames with one IDLE gap
    load_words(32'h600); expect_load(32'h600); expect_load(32'h700);
    screen_end = 1'b1;
    tick();                                  // STALL
    screen_end = 1'b0;
    load_words(32'h700);
    tick();                                  // LOAD0
    tick();                                  // LOAD1
    screen_end = 1'b1;
    tick();                                  // LOAD2
    count_run(1'b1, "pend_a", n);
    count_run(1'b1, "pend_b", n2);
    check("pend_first_rest", n, 64'd4);
    check("pend_second_len", n2, 64'd7);
    tick();
    screen_end = 1'b0;
    check("pend_overrun", {63'd0, overrun}, 64'd0);
    check("pend_frames", {48'd0, frame_count}, 64'd5);
    check("pend_q_empty", exp_q.size(), 64'd0);
    tick();

    // Third edge in one sequence is dropped and flags overrun
    load_words(32'h800); expect_load(32'h800); expect_load(32'h800);
    screen_end = 1'b1;
    tick();                                  // STALL
    screen_end = 1'b0;
    tick();                                  // LOAD0
    screen_end = 1'b1;
    tick();                                  // LOAD1
    screen_end = 1'b0;
    tick();                                  // LOAD2
    screen_end = 1'b1;
    tick();                                  // LOAD3
    count_run(1'b1, "ovr_a", n);
    count_run(1'b1, "ovr_b", n2);
    check("ovr_first_rest", n, 64'd3);
    check("ovr_second_len", n2, 64'd7);
    tick();
    check("ovr_flag", {63'd0, overrun}, 64'd1);
    check("ovr_no_third", {63'd0, cpu_stall}, 64'd0);
    check("ovr_frames", {48'd0, frame_count}, 64'd7);
    screen_end = 1'b0;
    tick();

    // Asynchronous reset in the middle of LOAD
    load_words(32'h300);
    push_wr(5'd20, 32'h300); push_wr(5'd21, 32'h301);
    screen_end = 1'b1;
    tick();                                  // STALL
    screen_end = 1'b0;
    tick(); tick(); tick();                  // LOAD2
    reset = 1'b0;
    #1;
    check("mid_rst_stall",   {63'd0, cpu_stall}, 64'd0);
    check("mid_rst_rf_we",   {63'd0, rf_we}, 64'd0);
    check("mid_rst_ball_x",  {32'd0, ball_x}, 64'd0);
    check("mid_rst_ball_y",  {32'd0, ball_y}, 64'd0);
    check("mid_rst_frames",  {48'd0, frame_count}, 64'd0);
    check("mid_rst_flags",   {62'd0, overrun, conflict}, 64'd0);
    check("mid_rst_q_empty", exp_q.size(), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    tick();
    cpu_write(5'd3, 32'h55);
    load_words(32'h400); expect_load(32'h400);
    screen_end = 1'b1;
    tick();
    count_run(1'b1, "post_rst", n);
    check("post_rst_stall_len", n, 64'd7);
    tick();
    screen_end = 1'b0;
    check("post_rst_frames", {48'd0, frame_count}, 64'd1);
    check("post_rst_ball_x", {32'd0, ball_x}, 64'h150);
    check("post_rst_ball_y", {32'd0, ball_y}, 64'hF0);
    check("post_rst_r3", {32'd0, regs[3]}, 64'h55);
    tick();

    // Frame counter wrap
    force dut.frame_count = 16'hFFFF;
    #1;
    release dut.frame_count;
    tick();
    load_words(32'h500); expect_load(32'h500);
    screen_end = 1'b1;
    tick();
    count_run(1'b1, "wrap", n);
    tick();
    screen_end = 1'b0;
    check("wrap_frames", {48'd0, frame_count}, 64'd0);
    check("final_q_empty", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pong_frame_scheduler.md
Name: pong_frame_scheduler

Overview:
- Per-frame sequencer sitting between the processor, the game-I/O logic and the regfile write port.
- On each screen-end pulse it stalls the processor and loads a snapshot of game inputs (ball init, paddle bounds, limits) into fixed registers, one per cycle.
- It then reads back the ball x/y registers into stable output holding registers for the VGA side, and finally releases the processor.
- Between frames the processor owns the regfile write port unchanged.

Parameters:
- NUM_IN, 4, number of 32-bit input words loaded per frame (1..8).
- IN_BASE_REG, 20, first regfile index written; words go to IN_BASE_REG..IN_BASE_REG+NUM_IN-1 (sum must be ≤31).
- BALLX_REG, 28, regfile index holding ball x.
- BALLY_REG, 29, regfile index holding ball y.

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- screen_end  input  1  level from VGA timing; rising edge starts a frame sequence
- in_data  input  NUM_IN*32  input words; word i = in_data[32i+31:32i]
- cpu_we  input  1  processor regfile write enable
- cpu_wreg  input  5  processor write register index
- cpu_wdata  input  32  processor write data
- rf_we  output  1  regfile write enable (muxed)
- rf_wreg  output  5  regfile write index (muxed)
- rf_wdata  output  32  regfile write data (muxed)
- rf_rreg  output  5  index for dedicated regfile read port
- rf_rdata  input  32  combinational read data for rf_rreg, same cycle
- cpu_stall  output  1  processor must hold PC and suppress writes
- ball_x  output  32  latched ball x, stable between frames
- ball_y  output  32  latched ball y
- frame_count  output  16  completed sequences, wraps at 0xFFFF→0
- overrun  output  1  sticky: a screen-end edge was lost
- conflict  output  1  sticky: cpu_we seen while cpu_stall=1

Behaviour:
- Reset (reset=0, async) applies these values:
  - State is IDLE.
  - All outputs are 0, including cpu_stall, rf_we, ball_x, ball_y, frame_count, overrun and conflict.
  - The edge-detect register is 0 and the pending flag is 0.
- Edge detect: a registered copy of screen_end is kept; edge = screen_end & ~prev.
- IDLE behaviour:
  - rf_we/rf_wreg/rf_wdata pass cpu_we/cpu_wreg/cpu_wdata combinationally.
  - cpu_stall=0.
  - On edge (or pending=1), capture in_data into an internal snapshot, clear pending, and go to STALL.
  - A CPU write in the edge cycle still completes.
- STALL (1 cycle): cpu_stall=1, rf_we=0. This cycle drains any in-flight processor write stage. Next state is LOAD with index i=0.
- LOAD (NUM_IN cycles):
  - Outputs: cpu_stall=1, rf_we=1, rf_wreg=IN_BASE_REG+i, rf_wdata=snapshot word i.
  - i increments each cycle; after i=NUM_IN-1 go to RDX.
- RDX (1 cycle): cpu_stall=1, rf_we=0, rf_rreg=BALLX_REG. ball_x<=rf_rdata at the end of the cycle.
- RDY (1 cycle): rf_rreg=BALLY_REG. ball_y<=rf_rdata at the end of the cycle, frame_count increments, and the next state is IDLE.
- cpu_stall deasserts in the IDLE cycle after RDY.
- Total stall is NUM_IN+3 cycles.
- rf_rreg is 0 outside RDX/RDY.
- Edges while not IDLE:
  - The first edge sets pending, which is serviced immediately on return to IDLE (no idle gap beyond that one IDLE cycle).
  - An edge while pending is already set is dropped and sets overrun.
- cpu_we=1 while cpu_stall=1 is ignored (never reaches the regfile) and sets conflict.
- Sticky flags clear only on reset.
- ball_x/ball_y change only at the end of RDX/RDY, never mid-frame.
- Reset mid-sequence returns to IDLE immediately, with cpu_stall=0 and the latched ball values cleared.
- A partial LOAD is not resumed.

Test Plan:
- Reset then screen_end 0→1 with NUM_IN=4, in_data words {5,6,7,8}:
  - Regfile writes r20=5, r21=6, r22=7, r23=8 on consecutive cycles.
  - cpu_stall is high for exactly 7 cycles.
  - frame_count=1.
- Preload r28=0x140, r29=0xF0, then trigger a frame → ball_x=0x140, ball_y=0xF0 after RDY. Both hold while the CPU later writes r28=0x150, until the next frame.
- CPU write (r5=0x1234) in the edge cycle → write lands. cpu_we=1 during LOAD → no regfile write from the CPU, conflict=1.
- Second screen_end edge during LOAD → pending; a new sequence starts in the cycle after returning to IDLE, with no overrun. A third edge within the same sequence sets overrun=1.
- Assert reset during LOAD at i=2 → outputs zero asynchronously. After release, IDLE passes CPU writes, and the next edge runs a full 4-word load.
- Run 65536 frames (or force the counter to 0xFFFF) → frame_count wraps to 0.
